jk_q_monitor: RTL

Downstream stage for the JK-via-T flip-flop. It samples the flip-flop output q every clock and detects rising and falling edges. It counts toggles, measures the length of each completed high and low period, and flags a stuck output. Its status feeds the bench scoreboard and the debug registers of the flip-flop bank.

---
 rtl/jk_q_monitor.sv | 135 +++++++++++++
 1 files changed

// File: rtl/jk_q_monitor.sv
// Edge, period and stuck monitor for the JK-via-T flip-flop q output.
// Registered pulses; lengths reported only for periods that start after an edge.
module jk_q_monitor #(
  parameter int CNT_W       = 16,
  parameter int STUCK_LIMIT = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             q_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic             len_valid,
  output logic             stuck
);

  typedef enum logic [1:0] {
    ARM,
    SYNC,
    HIGH,
    LOW
  } state_t;

  localparam logic [CNT_W:0]   LIMIT   = (CNT_W+1)'(STUCK_LIMIT);
  localparam logic [CNT_W-1:0] RUN_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_nx;
  logic             q_d, q_d_nx;
  logic [CNT_W-1:0] run_cnt, run_nx;
  logic [CNT_W-1:0] tog_nx, hl_nx, ll_nx;
  logic             rise_nx, fall_nx, lv_nx, stuck_nx;
  logic             rise, fall, edge_s;
  logic [CNT_W:0]   run_inc;
  logic [CNT_W-1:0] run_sat;

  assign rise    = q_in & ~q_d;
  assign fall    = ~q_in & q_d;
  assign edge_s  = rise | fall;
  assign run_inc = {1'b0, run_cnt} + (CNT_W+1)'(1);
  assign run_sat = run_inc[CNT_W] ? RUN_MAX : run_inc[CNT_W-1:0];

  always_comb begin
    state_nx = state;
    q_d_nx   = q_d;
    run_nx   = run_cnt;
    tog_nx   = toggle_cnt;
    hl_nx    = high_len;
    ll_nx    = low_len;
    stuck_nx = stuck;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    lv_nx    = 1'b0;
    if (clr) begin
      state_nx = ARM;
      q_d_nx   = 1'b0;
      run_nx   = '0;
      tog_nx   = '0;
      hl_nx    = '0;
      ll_nx    = '0;
      stuck_nx = 1'b0;
    end else if (en) begin
      q_d_nx = q_in;
      if (state == ARM) begin
        run_nx   = ONE;
        state_nx = SYNC;
      end else begin
        rise_nx = rise;
        fall_nx = fall;
        if (edge_s) begin
          tog_nx   = toggle_cnt + ONE;
          run_nx   = ONE;
          stuck_nx = 1'b0;
        end else begin
          run_nx = run_sat;
          if (run_inc >= LIMIT)
            stuck_nx = 1'b1;
        end
        // level seen in SYNC is partial, so it never yields a length
        unique case (state)
          SYNC: begin
            if (edge_s)
              state_nx = q_in ? HIGH : LOW;
          end
          HIGH: begin
            if (fall) begin
              hl_nx    = run_cnt;
              lv_nx    = 1'b1;
              state_nx = LOW;
            end
          end
          LOW: begin
            if (rise) begin
              ll_nx    = run_cnt;
              lv_nx    = 1'b1;
              state_nx = HIGH;
            end
          end
          default: state_nx = SYNC;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARM;
      q_d        <= 1'b0;
      run_cnt    <= '0;
      toggle_cnt <= '0;
      high_len   <= '0;
      low_len    <= '0;
      stuck      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      len_valid  <= 1'b0;
    end else begin
      state      <= state_nx;
      q_d        <= q_d_nx;
      run_cnt    <= run_nx;
      toggle_cnt <= tog_nx;
      high_len   <= hl_nx;
      low_len    <= ll_nx;
      stuck      <= stuck_nx;
      rise_pulse <= rise_nx;
      fall_pulse <= fall_nx;
      len_valid  <= lv_nx;
    end
  end

endmodule
